// File: rtl/diff_freq_serial_out_core_pkg.sv
// Shared definitions for the byte-command serial pattern generator:
// command codes, channel mode encodings, ctrl-byte layout and parser states.
package diff_freq_serial_out_core_pkg;

  localparam logic [7:0] CMD_DATA   = 8'h01;
  localparam logic [7:0] CMD_CTRL   = 8'h02;
  localparam logic [7:0] CMD_FREQ   = 8'h03;
  localparam logic [7:0] CMD_PERIOD = 8'h04;
  localparam logic [7:0] CMD_REPEAT = 8'h05;
  localparam logic [7:0] CMD_GLOBAL = 8'h06;

  localparam logic [1:0] MODE_ONE_SHOT = 2'b00;
  localparam logic [1:0] MODE_CONTINUE = 2'b01;
  localparam logic [1:0] MODE_REPEAT   = 2'b10;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IDLE_BIT = 3;

  typedef enum logic [3:0] {
    ST_WAIT_CMD,
    ST_DATA_CH,
    ST_DATA_N,
    ST_DATA_BYTES,
    ST_CTRL_CH,
    ST_CTRL_BYTE,
    ST_FREQ_N,
    ST_FREQ_BYTES,
    ST_PER_SLOW,
    ST_PER_FAST,
    ST_REP_CH,
    ST_REP_CNT,
    ST_GLOBAL
  } parse_state_e;

  // Periods and repeat counts of zero are meaningless, so they read as one.
  function automatic logic [7:0] min_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/diff_freq_serial_out_core_serial_out.sv
// One serial output channel. Command writes land in pending registers and are
// copied into the active set at every pattern start, so a running pattern is
// never changed mid-iteration (a disable is the exception and acts at once).
module serial_out_channel
  import diff_freq_serial_out_core_pkg::*;
#(
  parameter int DATA_BIT = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic [DATA_BIT-1:0]            freq_map_i,
  input  logic [7:0]                     slow_period_i,
  input  logic [7:0]                     fast_period_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic                           data_we_i,
  input  logic [DATA_BIT-1:0]            pattern_i,
  input  logic [$clog2(DATA_BIT/8)-1:0]  n_i,
  input  logic                           ctrl_we_i,
  input  logic [3:0]                     ctrl_i,
  input  logic                           rep_we_i,
  input  logic [7:0]                     rep_i,
  output logic                           serial_out_o
);

  localparam int NW = $clog2(DATA_BIT / 8);
  localparam int IW = NW + 3;

  logic [DATA_BIT-1:0] pend_pat_q, pend_pat_d, act_pat_q, act_pat_d;
  logic [NW-1:0]       pend_n_q, pend_n_d, act_n_q, act_n_d;
  logic                pend_en_q, pend_en_d, pend_idle_q, pend_idle_d;
  logic [1:0]          pend_mode_q, pend_mode_d, act_mode_q, act_mode_d;
  logic [7:0]          pend_rep_q, pend_rep_d, rep_cnt_q, rep_cnt_d;
  logic                running_q, running_d, out_q, out_d;
  logic [IW-1:0]       bit_idx_q, bit_idx_d;
  logic [7:0]          per_cnt_q, per_cnt_d;
  logic                load, new_bit;
  logic [IW-1:0]       last_idx;

  assign last_idx     = {act_n_q, 3'b111};
  assign serial_out_o = out_q;

  // Channel state register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      pend_pat_q  <= '0;
      pend_n_q    <= '0;
      pend_en_q   <= 1'b0;
      pend_idle_q <= 1'b0;
      pend_mode_q <= MODE_ONE_SHOT;
      pend_rep_q  <= '0;
      act_pat_q   <= '0;
      act_n_q     <= '0;
      act_mode_q  <= MODE_ONE_SHOT;
      rep_cnt_q   <= '0;
      running_q   <= 1'b0;
      bit_idx_q   <= '0;
      per_cnt_q   <= '0;
      out_q       <= 1'b0;
    end else begin
      pend_pat_q  <= pend_pat_d;
      pend_n_q    <= pend_n_d;
      pend_en_q   <= pend_en_d;
      pend_idle_q <= pend_idle_d;
      pend_mode_q <= pend_mode_d;
      pend_rep_q  <= pend_rep_d;
      act_pat_q   <= act_pat_d;
      act_n_q     <= act_n_d;
      act_mode_q  <= act_mode_d;
      rep_cnt_q   <= rep_cnt_d;
      running_q   <= running_d;
      bit_idx_q   <= bit_idx_d;
      per_cnt_q   <= per_cnt_d;
      out_q       <= out_d;
    end
  end

  // Pending writes, start/stop, bit stepping and iteration wrap; the output
  // flop follows the bit that will be current after this edge.
  always_comb begin
    pend_pat_d  = pend_pat_q;
    pend_n_d    = pend_n_q;
    pend_en_d   = pend_en_q;
    pend_idle_d = pend_idle_q;
    pend_mode_d = pend_mode_q;
    pend_rep_d  = pend_rep_q;
    act_pat_d   = act_pat_q;
    act_n_d     = act_n_q;
    act_mode_d  = act_mode_q;
    rep_cnt_d   = rep_cnt_q;
    running_d   = running_q;
    bit_idx_d   = bit_idx_q;
    per_cnt_d   = per_cnt_q;
    load        = 1'b0;
    new_bit     = 1'b0;

    if (data_we_i) begin
      pend_pat_d = pattern_i;
      pend_n_d   = n_i;
    end
    if (ctrl_we_i) begin
      pend_en_d   = ctrl_i[CTRL_EN_BIT];
      pend_mode_d = ctrl_i[CTRL_MODE_LSB +: 2];
      pend_idle_d = ctrl_i[CTRL_IDLE_BIT];
    end
    if (rep_we_i) pend_rep_d = rep_i;

    if (stop_i || (ctrl_we_i && !ctrl_i[CTRL_EN_BIT])) begin
      running_d = 1'b0;
    end else if (start_i) begin
      running_d = pend_en_q;
      load      = 1'b1;
      rep_cnt_d = min_one(pend_rep_q) - 8'd1;
    end else if (running_q) begin
      if (per_cnt_q == 8'd0) begin
        if (bit_idx_q == last_idx) begin
          if (act_mode_q == MODE_CONTINUE) begin
            load      = 1'b1;
            rep_cnt_d = min_one(pend_rep_q) - 8'd1;
          end else if ((act_mode_q == MODE_REPEAT) && (rep_cnt_q != 8'd0)) begin
            load      = 1'b1;
            rep_cnt_d = rep_cnt_q - 8'd1;
          end else begin
            running_d = 1'b0;
          end
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          new_bit   = 1'b1;
        end
      end else begin
        per_cnt_d = per_cnt_q - 8'd1;
      end
    end

    if (load) begin
      act_pat_d  = pend_pat_q;
      act_n_d    = pend_n_q;
      act_mode_d = pend_mode_q;
      bit_idx_d  = '0;
      new_bit    = 1'b1;
    end
    if (new_bit) begin
      per_cnt_d = (freq_map_i[bit_idx_d] ? fast_period_i : slow_period_i) - 8'd1;
    end

    out_d = running_d ? act_pat_d[bit_idx_d] : pend_idle_d;
  end

endmodule

// File: rtl/diff_freq_serial_out_core.sv
// Top level: command parser FSM, shared freq map and periods, global
// start/stop, and the array of serial output channels.
module diff_freq_serial_out_core
  import diff_freq_serial_out_core_pkg::*;
#(
  parameter int DATA_BIT    = 64,
  parameter int OUTPUT_NUM  = 16,
  parameter int SLOW_PERIOD = 20,
  parameter int FAST_PERIOD = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [7:0]            data_i,
  input  logic                  rx_done_tick_i,
  output logic [OUTPUT_NUM-1:0] serial_out_o
);

  localparam int BYTES = DATA_BIT / 8;
  localparam int NW    = $clog2(BYTES);

  parse_state_e        state_q, state_d;
  logic [7:0]          ch_q, ch_d, n_q, n_d, cnt_q, cnt_d, idx_q, idx_d;
  logic [DATA_BIT-1:0] pat_buf_q, pat_buf_d, freq_map_q, freq_map_d;
  logic [7:0]          slow_q, slow_d, fast_q, fast_d;
  logic                data_we, freq_we, ctrl_we, rep_we, start, stop;
  logic [NW-1:0]       n_clip;

  assign n_clip = (n_q > 8'(BYTES - 1)) ? NW'(BYTES - 1) : n_q[NW-1:0];

  // Parser and shared-setting registers.
  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= ST_WAIT_CMD;
      ch_q       <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      pat_buf_q  <= '0;
      freq_map_q <= '0;
      slow_q     <= 8'(SLOW_PERIOD);
      fast_q     <= 8'(FAST_PERIOD);
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pat_buf_q  <= pat_buf_d;
      freq_map_q <= freq_map_d;
      slow_q     <= slow_d;
      fast_q     <= fast_d;
    end
  end

  // Next parser state: one state per command field, advancing on each tick.
  always_comb begin
    state_d = state_q;
    if (rx_done_tick_i) begin
      unique case (state_q)
        ST_WAIT_CMD: begin
          case (data_i)
            CMD_DATA:   state_d = ST_DATA_CH;
            CMD_CTRL:   state_d = ST_CTRL_CH;
            CMD_FREQ:   state_d = ST_FREQ_N;
            CMD_PERIOD: state_d = ST_PER_SLOW;
            CMD_REPEAT: state_d = ST_REP_CH;
            CMD_GLOBAL: state_d = ST_GLOBAL;
            default:    state_d = ST_WAIT_CMD;
          endcase
        end
        ST_DATA_CH:    state_d = ST_DATA_N;
        ST_DATA_N:     state_d = ST_DATA_BYTES;
        ST_FREQ_N:     state_d = ST_FREQ_BYTES;
        ST_DATA_BYTES,
        ST_FREQ_BYTES: if (cnt_q == 8'd0) state_d = ST_WAIT_CMD;
        ST_CTRL_CH:    state_d = ST_CTRL_BYTE;
        ST_REP_CH:     state_d = ST_REP_CNT;
        ST_PER_SLOW:   state_d = ST_PER_FAST;
        default:       state_d = ST_WAIT_CMD;
      endcase
    end
  end

  // Command field capture: byte staging, freq-map commit and period loads.
  always_comb begin
    ch_d       = ch_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pat_buf_d  = pat_buf_q;
    freq_map_d = freq_map_q;
    slow_d     = slow_q;
    fast_d     = fast_q;
    if (rx_done_tick_i) begin
      case (state_q)
        ST_DATA_CH, ST_CTRL_CH, ST_REP_CH: ch_d = data_i;
        ST_DATA_N, ST_FREQ_N: begin
          n_d       = data_i;
          cnt_d     = data_i;
          idx_d     = '0;
          pat_buf_d = '0;
        end
        ST_DATA_BYTES, ST_FREQ_BYTES: begin
          for (int b = 0; b < BYTES; b++) begin
            if (idx_q == 8'(b)) pat_buf_d[b*8 +: 8] = data_i;
          end
          cnt_d = cnt_q - 8'd1;
          idx_d = idx_q + 8'd1;
        end
        ST_PER_SLOW: slow_d = min_one(data_i);
        ST_PER_FAST: fast_d = min_one(data_i);
        default: ;
      endcase
    end
    if (freq_we) freq_map_d = pat_buf_d;
  end

  // Write and start/stop strobes issued on the final byte of each command.
  always_comb begin
    data_we = rx_done_tick_i && (state_q == ST_DATA_BYTES) && (cnt_q == 8'd0);
    freq_we = rx_done_tick_i && (state_q == ST_FREQ_BYTES) && (cnt_q == 8'd0);
    ctrl_we = rx_done_tick_i && (state_q == ST_CTRL_BYTE);
    rep_we  = rx_done_tick_i && (state_q == ST_REP_CNT);
    start   = rx_done_tick_i && (state_q == ST_GLOBAL) && data_i[0];
    stop    = rx_done_tick_i && (state_q == ST_GLOBAL) && !data_i[0];
  end

  for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_ch
    logic sel;
    assign sel = (ch_q == 8'(k));
    serial_out_channel #(.DATA_BIT(DATA_BIT)) u_ch (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .freq_map_i   (freq_map_q),
      .slow_period_i(slow_q),
      .fast_period_i(fast_q),
      .start_i      (start),
      .stop_i       (stop),
      .data_we_i    (data_we && sel),
      .pattern_i    (pat_buf_d),
      .n_i          (n_clip),
      .ctrl_we_i    (ctrl_we && sel),
      .ctrl_i       (data_i[3:0]),
      .rep_we_i     (rep_we && sel),
      .rep_i        (data_i),
      .serial_out_o (serial_out_o[k])
    );
  end

endmodule

// File: tb/tb_diff_freq_serial_out_core.sv
// Directed bench for diff_freq_serial_out_core: command bytes are driven on
// falling edges and outputs are compared on falling edges against values
// worked out from the pattern, freq map and periods of each scenario.
module tb_diff_freq_serial_out_core;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        rx_done_tick_i;
  logic [15:0] serial_out_o;

  int vecCount = 0;
  int errCount = 0;

  always #5 clk_i = ~clk_i;

  diff_freq_serial_out_core #(
    .DATA_BIT(64), .OUTPUT_NUM(16), .SLOW_PERIOD(20), .FAST_PERIOD(5)
  ) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .data_i        (data_i),
    .rx_done_tick_i(rx_done_tick_i),
    .serial_out_o  (serial_out_o)
  );

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One received byte: tick high for exactly one clock, entered on a negedge.
  task automatic applyStimulus(input logic [7:0] b);
    data_i         = b;
    rx_done_tick_i = 1'b1;
    @(negedge clk_i);
    rx_done_tick_i = 1'b0;
    data_i         = 8'h00;
  endtask

  task automatic sendData(input logic [7:0] ch, input int n, input logic [63:0] pat);
    applyStimulus(8'h01);
    applyStimulus(ch);
    applyStimulus(8'(n));
    for (int i = 0; i <= n; i++) applyStimulus((i < 8) ? pat[i*8 +: 8] : 8'hEE);
  endtask

  task automatic sendFreq(input int n, input logic [63:0] fmap);
    applyStimulus(8'h03);
    applyStimulus(8'(n));
    for (int i = 0; i <= n; i++) applyStimulus(fmap[i*8 +: 8]);
  endtask

  task automatic sendCtrl(input logic [7:0] ch, input logic [7:0] c);
    applyStimulus(8'h02); applyStimulus(ch); applyStimulus(c);
  endtask

  task automatic sendPeriod(input logic [7:0] s, input logic [7:0] f);
    applyStimulus(8'h04); applyStimulus(s); applyStimulus(f);
  endtask

  task automatic sendRepeat(input logic [7:0] ch, input logic [7:0] cnt);
    applyStimulus(8'h05); applyStimulus(ch); applyStimulus(cnt);
  endtask

  task automatic sendGlobal(input logic [7:0] g);
    applyStimulus(8'h06); applyStimulus(g);
  endtask

  task automatic checkBit(input string tag, input int ch, input logic expBit, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      checkOutput(tag, 16'(serial_out_o[ch]), 16'(expBit));
      @(negedge clk_i);
    end
  endtask

  task automatic checkVector(input string tag, input logic [15:0] expVec, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      checkOutput(tag, serial_out_o, expVec);
      @(negedge clk_i);
    end
  endtask

  // Expected waveform of one pattern iteration: bit i held for its period.
  task automatic checkPattern(input int ch, input logic [63:0] pat, input int nbits,
                              input logic [63:0] fmap, input int slowP, input int fastP);
    for (int i = 0; i < nbits; i++) begin
      checkBit($sformatf("ch%0d_bit%0d", ch, i), ch, pat[i], fmap[i] ? fastP : slowP);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    rx_done_tick_i = 1'b0;
    data_i         = 8'h00;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_out", serial_out_o, 16'h0000);
    rst_n = 1'b0;
    @(negedge clk_i);
    checkVector("post_reset_idle", 16'h0000, 4);

    // One-shot on ch0 with alternating fast/slow bits.
    sendFreq(2, 64'h555555);
    sendPeriod(8'h14, 8'h05);
    sendData(8'd0, 0, 64'h55);
    sendCtrl(8'd0, 8'h01);
    sendGlobal(8'h01);
    checkPattern(0, 64'h55, 8, 64'h555555, 20, 5);
    checkVector("t1_idle", 16'h0000, 10);

    // Repeat mode on ch15, idle level high.
    sendCtrl(8'd0, 8'h00);
    sendRepeat(8'd15, 8'd3);
    sendData(8'd15, 3, 64'h01010155);
    sendCtrl(8'd15, 8'h0D);
    checkVector("t2_idle_high", 16'h8000, 3);
    sendGlobal(8'h01);
    repeat (3) checkPattern(15, 64'h01010155, 32, 64'h555555, 20, 5);
    checkVector("t2_done_high", 16'h8000, 10);

    // Continuous mode on ch1, then a global stop.
    sendCtrl(8'd15, 8'h00);
    sendData(8'd1, 0, 64'h0F);
    sendCtrl(8'd1, 8'h03);
    sendGlobal(8'h01);
    repeat (3) checkPattern(1, 64'h0F, 8, 64'h555555, 20, 5);
    checkOutput("t3_before_stop", 16'(serial_out_o[1]), 16'h0001);
    sendGlobal(8'h00);
    checkVector("t3_stopped", 16'h0000, 5);

    // Out-of-range channel is consumed without effect; following CTRL lands.
    sendCtrl(8'd1, 8'h00);
    sendData(8'd20, 1, 64'hBBAA);
    sendCtrl(8'd2, 8'h09);
    checkVector("t4_ch2_idle", 16'h0004, 3);
    sendCtrl(8'd2, 8'h00);
    sendCtrl(8'd4, 8'h01);
    sendGlobal(8'h01);
    checkVector("t4_ch4_untouched", 16'h0000, 100);

    // Unknown byte ignored; zero periods act as one clock.
    sendCtrl(8'd4, 8'h00);
    applyStimulus(8'h7F);
    sendPeriod(8'h00, 8'h00);
    sendData(8'd3, 0, 64'hA5);
    sendCtrl(8'd3, 8'h01);
    sendGlobal(8'h01);
    checkPattern(3, 64'hA5, 8, 64'h555555, 1, 1);
    checkVector("t5_idle", 16'h0000, 4);

    // Reset in the middle of a transmission and of a PERIOD command.
    sendPeriod(8'd50, 8'd50);
    sendGlobal(8'h01);
    checkBit("t6_running", 3, 1'b1, 5);
    applyStimulus(8'h04);
    #2 rst_n = 1'b1;
    #1 checkOutput("t6_async_reset", serial_out_o, 16'h0000);
    @(negedge clk_i);
    checkOutput("t6_in_reset", serial_out_o, 16'h0000);
    rst_n = 1'b0;
    @(negedge clk_i);
    sendFreq(0, 64'h01);
    sendData(8'd0, 0, 64'h03);
    sendCtrl(8'd0, 8'h01);
    sendGlobal(8'h01);
    checkPattern(0, 64'h03, 8, 64'h01, 20, 5);
    checkVector("t6_idle", 16'h0000, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
